// File: rtl/dram_axil_to_axi4_bridge.sv
// AXI-Lite to Zynq HP0 AXI4 bridge: address relocation, 2-entry skids on
// all five channels, per-direction outstanding limits, sticky error flag.

module dram_axil_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         r_rdy;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_push    = i_valid & r_rdy;
  assign w_pop     = (r_cnt != 2'd0) & i_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
      r_rdy <= 1'b0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  // payload storage needs no reset; valid is qualified by r_cnt
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  assign o_ready = r_rdy;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
endmodule

module dram_axil_to_axi4_bridge #(
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 32,
  parameter int max_outstanding_p = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [addr_width_p-1:0]   dram_base_i,
  input  logic                      err_clr_i,
  output logic                      err_o,
  output logic [3:0]                wr_outstanding_o,
  output logic [3:0]                rd_outstanding_o,
  input  logic [addr_width_p-1:0]   s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [data_width_p-1:0]   s_axil_wdata,
  input  logic [data_width_p/8-1:0] s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [addr_width_p-1:0]   s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [data_width_p-1:0]   s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [addr_width_p-1:0]   m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [data_width_p-1:0]   m_axi_wdata,
  output logic [data_width_p/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [addr_width_p-1:0]   m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [data_width_p-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  input  logic                      m_axi_rlast,
  output logic                      m_axi_rready
);
  localparam int          SW   = data_width_p / 8;
  localparam logic [3:0]  MAXO = 4'(max_outstanding_p);

  logic [3:0] r_wr_cnt;
  logic [3:0] r_rd_cnt;
  logic       r_err;
  logic       w_aw_v;
  logic       w_ar_v;
  logic       w_wr_full;
  logic       w_rd_full;
  logic       w_aw_hs;
  logic       w_ar_hs;
  logic       w_b_hs;
  logic       w_r_hs;
  logic       w_err_set;

  function automatic logic [3:0] f_cnt(
    input logic [3:0] c,
    input logic       inc,
    input logic       dec
  );
    logic [3:0] n;
    n = c;
    if (inc && !dec) n = c + 4'd1;
    else if (dec && !inc && c != 4'd0) n = c - 4'd1;
    return n;
  endfunction

  dram_axil_skid #(.W(addr_width_p)) u_aw (
    .clk(aclk), .rst_n(aresetn),
    .i_data(s_axil_awaddr + dram_base_i),
    .i_valid(s_axil_awvalid), .o_ready(s_axil_awready),
    .o_data(m_axi_awaddr), .o_valid(w_aw_v),
    .i_ready(m_axi_awready & ~w_wr_full)
  );

  dram_axil_skid #(.W(data_width_p + SW)) u_w (
    .clk(aclk), .rst_n(aresetn),
    .i_data({s_axil_wstrb, s_axil_wdata}),
    .i_valid(s_axil_wvalid), .o_ready(s_axil_wready),
    .o_data({m_axi_wstrb, m_axi_wdata}), .o_valid(m_axi_wvalid),
    .i_ready(m_axi_wready)
  );

  dram_axil_skid #(.W(2)) u_b (
    .clk(aclk), .rst_n(aresetn),
    .i_data(m_axi_bresp),
    .i_valid(m_axi_bvalid), .o_ready(m_axi_bready),
    .o_data(s_axil_bresp), .o_valid(s_axil_bvalid),
    .i_ready(s_axil_bready)
  );

  dram_axil_skid #(.W(addr_width_p)) u_ar (
    .clk(aclk), .rst_n(aresetn),
    .i_data(s_axil_araddr + dram_base_i),
    .i_valid(s_axil_arvalid), .o_ready(s_axil_arready),
    .o_data(m_axi_araddr), .o_valid(w_ar_v),
    .i_ready(m_axi_arready & ~w_rd_full)
  );

  dram_axil_skid #(.W(data_width_p + 2)) u_r (
    .clk(aclk), .rst_n(aresetn),
    .i_data({m_axi_rdata, m_axi_rresp}),
    .i_valid(m_axi_rvalid), .o_ready(m_axi_rready),
    .o_data({s_axil_rdata, s_axil_rresp}), .o_valid(s_axil_rvalid),
    .i_ready(s_axil_rready)
  );

  // address stays parked in the skid while the limit is reached
  assign w_wr_full     = (r_wr_cnt == MAXO);
  assign w_rd_full     = (r_rd_cnt == MAXO);
  assign m_axi_awvalid = w_aw_v & ~w_wr_full;
  assign m_axi_arvalid = w_ar_v & ~w_rd_full;
  assign m_axi_wlast   = 1'b1;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;
  assign w_b_hs  = m_axi_bvalid & m_axi_bready;
  assign w_r_hs  = m_axi_rvalid & m_axi_rready;

  assign w_err_set =
    (w_b_hs & ((m_axi_bresp != 2'b00) | (r_wr_cnt == 4'd0))) |
    (w_r_hs & ((m_axi_rresp != 2'b00) | ~m_axi_rlast |
               (r_rd_cnt == 4'd0)));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_cnt <= 4'd0;
      r_rd_cnt <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_wr_cnt <= f_cnt(r_wr_cnt, w_aw_hs, w_b_hs);
      r_rd_cnt <= f_cnt(r_rd_cnt, w_ar_hs, w_r_hs);
      if (w_err_set) r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign err_o            = r_err;
  assign wr_outstanding_o = r_wr_cnt;
  assign rd_outstanding_o = r_rd_cnt;
endmodule

// File: tb/tb_dram_axil_to_axi4_bridge.sv
// Randomized bench for dram_axil_to_axi4_bridge with a queue scoreboard
// and a cycle-level model of the outstanding counters and error flag.

module tb_dram_axil_to_axi4_bridge;
  localparam int MAXO = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] dram_base_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_o;
  logic [3:0]  wr_outstanding_o;
  logic [3:0]  rd_outstanding_o;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wlast;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rready;

  dram_axil_to_axi4_bridge #(
    .data_width_p(32), .addr_width_p(32), .max_outstanding_p(MAXO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .dram_base_i(dram_base_i),
    .err_clr_i(err_clr_i), .err_o(err_o),
    .wr_outstanding_o(wr_outstanding_o),
    .rd_outstanding_o(rd_outstanding_o),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wlast(m_axi_wlast),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // stimulus sources
  logic [31:0] q_s_aw[$];
  logic [35:0] q_s_w[$];
  logic [31:0] q_s_ar[$];
  logic [1:0]  q_bresp[$];
  logic [34:0] q_rsrc[$];
  // scoreboard
  logic [31:0] q_exp_aw[$];
  logic [35:0] q_exp_w[$];
  logic [31:0] q_exp_ar[$];
  logic [1:0]  q_exp_b[$];
  logic [33:0] q_exp_r[$];

  bit mst_rand = 0;
  bit slv_rand = 0;
  int slv_mode = 0;
  bit r_hold = 0;
  bit b_inject = 0;
  bit f_s_aw, f_s_w, f_s_ar, f_m_b, f_m_r;
  int c_s_aw, c_m_aw, c_m_w, c_m_b, c_s_b, c_s_ar, c_m_ar, c_m_r, c_s_r;
  int m_wr, m_rd;
  bit m_err;
  logic [1:0]  last_bresp;
  logic [31:0] last_rdata;

  function automatic bit go(input bit r);
    return r ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  function automatic logic [1:0] rnd_resp();
    if (slv_rand && $urandom_range(0, 15) == 0)
      return 2'($urandom_range(1, 3));
    return 2'b00;
  endfunction

  // monitor: sample at negedge, score handshakes that fire at the next edge
  initial begin
    bit e_s_aw, e_m_aw, e_s_w, e_m_w, e_m_b, e_s_b;
    bit e_s_ar, e_m_ar, e_m_r, e_s_r, set;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_wr = 0; m_rd = 0; m_err = 0;
        q_exp_aw.delete(); q_exp_w.delete(); q_exp_ar.delete();
        q_exp_b.delete(); q_exp_r.delete();
        {f_s_aw, f_s_w, f_s_ar, f_m_b, f_m_r} = '0;
        c_s_aw = 0; c_m_aw = 0; c_m_w = 0; c_m_b = 0; c_s_b = 0;
        c_s_ar = 0; c_m_ar = 0; c_m_r = 0; c_s_r = 0;
        continue;
      end
      chk("wr_cnt", 64'(wr_outstanding_o), 64'(m_wr));
      chk("rd_cnt", 64'(rd_outstanding_o), 64'(m_rd));
      chk("err", 64'(err_o), 64'(m_err));
      if (m_wr == MAXO) chk("aw_gate", 64'(m_axi_awvalid), 64'(0));
      if (m_rd == MAXO) chk("ar_gate", 64'(m_axi_arvalid), 64'(0));
      e_s_aw = s_axil_awvalid & s_axil_awready;
      e_m_aw = m_axi_awvalid & m_axi_awready;
      e_s_w  = s_axil_wvalid & s_axil_wready;
      e_m_w  = m_axi_wvalid & m_axi_wready;
      e_m_b  = m_axi_bvalid & m_axi_bready;
      e_s_b  = s_axil_bvalid & s_axil_bready;
      e_s_ar = s_axil_arvalid & s_axil_arready;
      e_m_ar = m_axi_arvalid & m_axi_arready;
      e_m_r  = m_axi_rvalid & m_axi_rready;
      e_s_r  = s_axil_rvalid & s_axil_rready;
      if (e_m_aw) begin
        c_m_aw++;
        if (q_exp_aw.size() == 0) chk("aw_extra", 64'(1), 64'(0));
        else chk("awaddr", 64'(m_axi_awaddr), 64'(q_exp_aw.pop_front()));
      end
      if (e_s_aw) begin
        c_s_aw++; f_s_aw = 1;
        q_exp_aw.push_back(s_axil_awaddr + dram_base_i);
      end
      if (e_m_w) begin
        c_m_w++;
        chk("wlast", 64'(m_axi_wlast), 64'(1));
        if (q_exp_w.size() == 0) chk("w_extra", 64'(1), 64'(0));
        else chk("wdata", 64'({m_axi_wstrb, m_axi_wdata}),
                 64'(q_exp_w.pop_front()));
      end
      if (e_s_w) begin
        c_s_w_push: q_exp_w.push_back({s_axil_wstrb, s_axil_wdata});
        f_s_w = 1;
      end
      if (e_s_b) begin
        c_s_b++; last_bresp = s_axil_bresp;
        if (q_exp_b.size() == 0) chk("b_extra", 64'(1), 64'(0));
        else chk("bresp", 64'(s_axil_bresp), 64'(q_exp_b.pop_front()));
      end
      if (e_m_b) begin
        c_m_b++; f_m_b = 1;
        q_exp_b.push_back(m_axi_bresp);
      end
      if (e_m_ar) begin
        c_m_ar++;
        if (q_exp_ar.size() == 0) chk("ar_extra", 64'(1), 64'(0));
        else chk("araddr", 64'(m_axi_araddr), 64'(q_exp_ar.pop_front()));
      end
      if (e_s_ar) begin
        c_s_ar++; f_s_ar = 1;
        q_exp_ar.push_back(s_axil_araddr + dram_base_i);
      end
      if (e_s_r) begin
        c_s_r++; last_rdata = s_axil_rdata;
        if (q_exp_r.size() == 0) chk("r_extra", 64'(1), 64'(0));
        else chk("rdata", 64'({s_axil_rdata, s_axil_rresp}),
                 64'(q_exp_r.pop_front()));
      end
      if (e_m_r) begin
        c_m_r++; f_m_r = 1;
        q_exp_r.push_back({m_axi_rdata, m_axi_rresp});
      end
      set = (e_m_b && (m_axi_bresp != 2'b00 || m_wr == 0)) ||
            (e_m_r && (m_axi_rresp != 2'b00 || !m_axi_rlast || m_rd == 0));
      m_err = set ? 1'b1 : (err_clr_i ? 1'b0 : m_err);
      if (e_m_aw && !e_m_b) m_wr++;
      else if (e_m_b && !e_m_aw && m_wr > 0) m_wr--;
      if (e_m_ar && !e_m_r) m_rd++;
      else if (e_m_r && !e_m_ar && m_rd > 0) m_rd--;
    end
  end

  // driver: AXI-Lite master on s side, HP0 slave model on m side
  initial begin
    int b_iss, r_iss, need;
    b_iss = 0; r_iss = 0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        {s_axil_awvalid, s_axil_wvalid, s_axil_arvalid} = '0;
        {s_axil_bready, s_axil_rready} = '0;
        {m_axi_awready, m_axi_wready, m_axi_arready} = '0;
        {m_axi_bvalid, m_axi_rvalid} = '0;
        q_s_aw.delete(); q_s_w.delete(); q_s_ar.delete();
        q_bresp.delete(); q_rsrc.delete();
        b_iss = 0; r_iss = 0; b_inject = 0;
        continue;
      end
      if (f_s_aw) begin void'(q_s_aw.pop_front()); f_s_aw = 0; s_axil_awvalid = 0; end
      if (!s_axil_awvalid && q_s_aw.size() > 0 && go(mst_rand)) s_axil_awvalid = 1;
      if (s_axil_awvalid) s_axil_awaddr = q_s_aw[0];
      if (f_s_w) begin void'(q_s_w.pop_front()); f_s_w = 0; s_axil_wvalid = 0; end
      if (!s_axil_wvalid && q_s_w.size() > 0 && go(mst_rand)) s_axil_wvalid = 1;
      if (s_axil_wvalid) {s_axil_wstrb, s_axil_wdata} = q_s_w[0];
      if (f_s_ar) begin void'(q_s_ar.pop_front()); f_s_ar = 0; s_axil_arvalid = 0; end
      if (!s_axil_arvalid && q_s_ar.size() > 0 && go(mst_rand)) s_axil_arvalid = 1;
      if (s_axil_arvalid) s_axil_araddr = q_s_ar[0];
      s_axil_bready = go(mst_rand);
      s_axil_rready = go(mst_rand);
      m_axi_awready = (slv_mode == 1) ? go(1) : 1'b1;
      m_axi_arready = (slv_mode == 1) ? go(1) : 1'b1;
      m_axi_wready  = (slv_mode == 2) ? ~m_axi_wready :
                      (slv_mode == 1) ? go(1) : 1'b1;
      if (f_m_b) begin m_axi_bvalid = 0; f_m_b = 0; end
      need = (c_m_aw < c_m_w) ? c_m_aw : c_m_w;
      if (!m_axi_bvalid && (b_iss < need || b_inject) && go(slv_rand)) begin
        if (b_inject) b_inject = 0;
        else b_iss++;
        m_axi_bvalid = 1;
        m_axi_bresp = (q_bresp.size() > 0) ? q_bresp.pop_front() : rnd_resp();
      end
      if (f_m_r) begin m_axi_rvalid = 0; f_m_r = 0; end
      if (!m_axi_rvalid && r_iss < c_m_ar && !r_hold && go(slv_rand)) begin
        r_iss++;
        m_axi_rvalid = 1;
        if (q_rsrc.size() > 0) begin
          {m_axi_rlast, m_axi_rresp, m_axi_rdata} = q_rsrc.pop_front();
        end else begin
          m_axi_rdata = $urandom;
          m_axi_rresp = rnd_resp();
          m_axi_rlast = slv_rand ? ($urandom_range(0, 15) != 0) : 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0: return c_s_b;
      1: return c_s_r;
      2: return c_m_r;
      3: return c_m_b;
      4: return c_s_aw;
      default: return c_s_ar;
    endcase
  endfunction

  task automatic wait_ge(input string tag, input int which,
                         input int target, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (cnt_of(which) >= target) break;
      tick(1);
    end
    chk(tag, 64'(cnt_of(which) >= target), 64'(1));
  endtask

  initial begin
    int b0;
    #1 aresetn = 0;
    tick(2);
    chk("rst_valid", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                          s_axil_bvalid, s_axil_rvalid}), 64'(0));
    chk("rst_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready,
                          m_axi_bready, m_axi_rready}), 64'(0));
    chk("rst_cnt", 64'({wr_outstanding_o, rd_outstanding_o, err_o}), 64'(0));
    aresetn = 1;
    tick(1);
    chk("rel_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready,
                          m_axi_bready, m_axi_rready}), 64'h1f);

    // basic relocated write
    dram_base_i = 32'h1000_0000;
    q_s_w.push_back({4'hf, 32'hDEADBEEF});
    q_s_aw.push_back(32'h40);
    wait_ge("t1_aw_to", 4, 1, 20);
    chk("t1_awvalid", 64'(m_axi_awvalid), 64'(1));
    chk("t1_awaddr", 64'(m_axi_awaddr), 64'h1000_0040);
    wait_ge("t1_b_to", 0, 1, 30);
    chk("t1_bresp", 64'(last_bresp), 64'(0));
    tick(2);
    chk("t1_wrcnt", 64'(wr_outstanding_o), 64'(0));

    // W before AW, then AW before W
    b0 = c_s_b;
    q_s_w.push_back({4'h3, 32'h1111_2222});
    tick(3);
    q_s_aw.push_back(32'h80);
    tick(3);
    q_s_aw.push_back(32'h84);
    tick(3);
    q_s_w.push_back({4'hc, 32'h3333_4444});
    wait_ge("t2_b_to", 0, b0 + 2, 50);
    tick(3);
    chk("t2_bcnt", 64'(c_s_b - b0), 64'(2));

    // wrapping read relocation
    dram_base_i = 32'hFFFF_FFF0;
    q_rsrc.push_back({1'b1, 2'b00, 32'h1234_5678});
    q_s_ar.push_back(32'h20);
    wait_ge("t3_ar_to", 5, 1, 20);
    chk("t3_araddr", 64'(m_axi_araddr), 64'h10);
    wait_ge("t3_r_to", 1, 1, 30);
    chk("t3_rdata", 64'(last_rdata), 64'h1234_5678);

    // read outstanding limit
    b0 = c_m_ar;
    r_hold = 1;
    for (int i = 0; i < 6; i++) q_s_ar.push_back(32'h100 + 32'(4 * i));
    tick(12);
    chk("t4_ar_hs", 64'(c_m_ar - b0), 64'(4));
    chk("t4_rdcnt", 64'(rd_outstanding_o), 64'(4));
    chk("t4_arvalid", 64'(m_axi_arvalid), 64'(0));
    r_hold = 0;
    wait_ge("t4_r_to", 1, c_s_r + 6, 100);
    chk("t4_ar_all", 64'(c_m_ar - b0), 64'(6));

    // sticky error and clear
    b0 = c_m_r;
    q_rsrc.push_back({1'b1, 2'b10, 32'hBAD0_0001});
    q_s_ar.push_back(32'h200);
    wait_ge("t5_r_to", 2, b0 + 1, 30);
    chk("t5_err_set", 64'(err_o), 64'(1));
    tick(3);
    chk("t5_err_hold", 64'(err_o), 64'(1));
    err_clr_i = 1;
    tick(1);
    err_clr_i = 0;
    chk("t5_err_clr", 64'(err_o), 64'(0));
    err_clr_i = 1;
    q_rsrc.push_back({1'b1, 2'b10, 32'hBAD0_0002});
    q_s_ar.push_back(32'h204);
    wait_ge("t5_r2_to", 2, b0 + 2, 30);
    err_clr_i = 0;
    chk("t5_set_wins", 64'(err_o), 64'(1));
    err_clr_i = 1; tick(1); err_clr_i = 0;
    q_rsrc.push_back({1'b0, 2'b00, 32'h0000_0003});
    q_s_ar.push_back(32'h208);
    wait_ge("t5_r3_to", 2, b0 + 3, 30);
    chk("t5_rlast_err", 64'(err_o), 64'(1));
    err_clr_i = 1; tick(2); err_clr_i = 0;
    b0 = c_m_b;
    b_inject = 1;
    wait_ge("t5_ub_to", 3, b0 + 1, 20);
    chk("t5_under_err", 64'(err_o), 64'(1));
    chk("t5_under_cnt", 64'(wr_outstanding_o), 64'(0));
    err_clr_i = 1; tick(1); err_clr_i = 0;
    tick(4);

    // 16 writes with toggling wready
    slv_mode = 2;
    b0 = c_s_b;
    for (int i = 0; i < 16; i++) begin
      q_s_aw.push_back(32'h1000 + 32'(4 * i));
      q_s_w.push_back({4'($urandom), 32'($urandom)});
    end
    wait_ge("t6_b_to", 0, b0 + 16, 300);
    tick(3);
    chk("t6_wcnt", 64'(wr_outstanding_o), 64'(0));
    chk("t6_wq", 64'(q_exp_w.size()), 64'(0));

    // reset in the middle of a burst
    for (int i = 0; i < 16; i++) begin
      q_s_aw.push_back(32'h2000 + 32'(4 * i));
      q_s_w.push_back({4'hf, 32'($urandom)});
    end
    tick(4);
    #1 aresetn = 0;
    #1;
    chk("t7_valid", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                         s_axil_bvalid, s_axil_rvalid}), 64'(0));
    chk("t7_cnt", 64'({wr_outstanding_o, rd_outstanding_o}), 64'(0));
    chk("t7_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready,
                         m_axi_bready, m_axi_rready}), 64'(0));
    tick(3);
    aresetn = 1;
    tick(1);
    chk("t7_rel_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready,
                             m_axi_bready, m_axi_rready}), 64'h1f);

    // randomized traffic against the scoreboard and cycle model
    slv_mode = 1; slv_rand = 1; mst_rand = 1;
    for (int i = 0; i < 40; i++) begin
      q_s_aw.push_back($urandom);
      q_s_w.push_back({4'($urandom), 32'($urandom)});
      q_s_ar.push_back($urandom);
    end
    for (int i = 0; i < 3000; i++) begin
      if (c_s_b >= 40 && c_s_r >= 40) break;
      dram_base_i = $urandom;
      err_clr_i = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    err_clr_i = 0;
    chk("t8_b_done", 64'(c_s_b), 64'(40));
    chk("t8_r_done", 64'(c_s_r), 64'(40));
    tick(4);
    chk("t8_wrcnt", 64'(wr_outstanding_o), 64'(0));
    chk("t8_rdcnt", 64'(rd_outstanding_o), 64'(0));
    chk("t8_queues", 64'(q_exp_aw.size() + q_exp_w.size() + q_exp_ar.size() +
                         q_exp_b.size() + q_exp_r.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
